// File: rtl/commit_trace_buffer_pkg.sv
// Shared record layout for the commit trace path: record width and field offsets,
// used by the buffer, by downstream bridges and by anything that decodes records.
package commit_trace_buffer_pkg;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    localparam int INSTR_W    = 32;
    localparam int RD_W       = 5;

    // Record is {pc, instr, we, rd, wdata} with pc in the MSBs.
    localparam int TRACE_REC_W = DEF_ADDR_W + INSTR_W + 1 + RD_W + DEF_DATA_W;
    localparam int WDATA_LSB   = 0;
    localparam int RD_LSB      = WDATA_LSB + DEF_DATA_W;
    localparam int WE_BIT      = RD_LSB + RD_W;
    localparam int INSTR_LSB   = WE_BIT + 1;
    localparam int PC_LSB      = INSTR_LSB + INSTR_W;

    function automatic int rec_w(input int addr_w, input int data_w);
        return addr_w + INSTR_W + 1 + RD_W + data_w;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_sync_fifo.sv
// First-word fall-through FIFO over registered storage; full/empty derive from the
// occupancy counter. A push into a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Simultaneous pop frees the slot the push lands in, so full+push+pop is lossless.
    assign wr_en = push & ~flush & (~full | pop);
    assign rd_en = pop & ~flush & ~empty;

    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures one record per retired instruction into a FIFO drained over valid/ready;
// counts records lost to a full buffer and flags the first such loss.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           trace_en,
    input  logic                           clear,
    input  logic                           commit_valid,
    input  logic [ADDR_W-1:0]              commit_pc,
    input  logic [31:0]                    commit_instr,
    input  logic                           commit_we,
    input  logic [4:0]                     commit_rd,
    input  logic [DATA_W-1:0]              commit_wdata,
    output logic                           trace_valid,
    input  logic                           trace_ready,
    output logic [ADDR_W+32+6+DATA_W-1:0]  trace_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow,
    output logic [CNT_W-1:0]               drop_cnt,
    output logic                           almost_full
);

    localparam int REC_W = rec_w(ADDR_W, DATA_W);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - 2);

    // Handshake: a record transfers on any edge where trace_valid & trace_ready are
    // both high; trace_data holds steady while trace_valid is high and ready is low.
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign rec  = {commit_pc, commit_instr, commit_we, commit_rd, commit_wdata};
    assign push = trace_en & commit_valid & ~clear;
    assign pop  = ~fifo_empty & trace_ready & ~clear;
    assign drop = push & fifo_full & ~pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .flush   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (rec),
        .rd_data (trace_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign trace_valid = ~fifo_empty;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;
    assign almost_full = (count >= AF_LEVEL);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and randomized bench for commit_trace_buffer against a queue-based model.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int RW    = TRACE_REC_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          trace_en, clear, commit_valid, commit_we, trace_ready;
    logic [31:0]   commit_pc, commit_instr, commit_wdata;
    logic [4:0]    commit_rd;
    logic          trace_valid, overflow, almost_full;
    logic [RW-1:0] trace_data;
    logic [4:0]    count;
    logic [15:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [RW-1:0] exp_q[$];
    bit            m_ovf;
    int            m_drop;

    always #5 clk = ~clk;

    commit_trace_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .trace_en     (trace_en),
        .clear        (clear),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .commit_we    (commit_we),
        .commit_rd    (commit_rd),
        .commit_wdata (commit_wdata),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_data   (trace_data),
        .count        (count),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .almost_full  (almost_full)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("trace_valid", trace_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) chk("trace_data", trace_data, exp_q[0]);
        chk("count", count, exp_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("almost_full", almost_full, (exp_q.size() >= DEPTH - 2));
    endtask

    // Called at a falling edge: check, drive, advance model over the next rising edge.
    task automatic cyc(input bit te, input bit cv, input bit rdy, input bit clr,
                       input logic [31:0] pc, input logic [31:0] instr, input bit we,
                       input logic [4:0] rd, input logic [31:0] wd);
        bit do_push, do_pop;
        check_model();
        trace_en = te; commit_valid = cv; trace_ready = rdy; clear = clr;
        commit_pc = pc; commit_instr = instr; commit_we = we; commit_rd = rd; commit_wdata = wd;
        do_push = te && cv && !clr;
        do_pop  = (exp_q.size() != 0) && rdy && !clr;
        if (clr) begin
            exp_q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({pc, instr, we, rd, wd});
                else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic push_pc(input logic [31:0] pc, input bit rdy);
        cyc(1, 1, rdy, 0, pc, $urandom, $urandom_range(0, 1), 5'($urandom), $urandom);
    endtask

    task automatic idle(input bit te, input bit rdy);
        cyc(te, 0, rdy, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    logic [RW-1:0] pack_exp;

    initial begin
        reset = 1'b1; trace_en = 0; clear = 0; commit_valid = 0; trace_ready = 0;
        commit_pc = 0; commit_instr = 0; commit_we = 0; commit_rd = 0; commit_wdata = 0;
        m_ovf = 0; m_drop = 0;
        #3;
        chk("rst_valid", trace_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_af", almost_full, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // basic order
        for (int i = 0; i < 3; i++) push_pc(32'(4 * i), 0);
        chk("basic_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("basic_pc", trace_data[PC_LSB +: 32], 32'(4 * i));
            idle(1, 1);
        end
        chk("basic_empty", trace_valid, 1'b0);

        // overflow: 20 pushes into 16 entries
        for (int i = 0; i < 20; i++) push_pc(32'(100 + 4 * i), 0);
        chk("ovf_count", count, 16);
        chk("ovf_af", almost_full, 1'b1);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drop", drop_cnt, 4);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_pc", trace_data[PC_LSB +: 32], 32'(100 + 4 * i));
            idle(1, 1);
        end
        chk("ovf_drained", trace_valid, 1'b0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_drop", drop_cnt, 0);

        // full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push_pc(32'(300 + 4 * i), 0);
        for (int i = 0; i < 5; i++) push_pc(32'(364 + 4 * i), 1);
        chk("fpp_drop", drop_cnt, 0);
        chk("fpp_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("fpp_pc", trace_data[PC_LSB +: 32], 32'(320 + 4 * i));
            idle(1, 1);
        end

        // field packing: addi x5, x0, 7 at pc 0x10
        cyc(1, 1, 0, 0, 32'h10, 32'h00700293, 1, 5'd5, 32'd7);
        pack_exp = {32'h10, 32'h00700293, 1'b1, 5'd5, 32'd7};
        chk("pack", trace_data, pack_exp);
        chk("pack_rd", trace_data[RD_LSB +: 5], 5'd5);
        chk("pack_we", trace_data[WE_BIT], 1'b1);
        idle(1, 1);

        // clear with 10 stored, then disabled commits
        for (int i = 0; i < 10; i++) push_pc(32'(600 + 4 * i), 0);
        chk("ce_count10", count, 10);
        cyc(1, 1, 1, 1, 32'h999, 0, 0, 0, 0);
        chk("ce_count0", count, 0);
        chk("ce_valid", trace_valid, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'(700 + 4 * i), $urandom, 1, 5'd1, $urandom);
        chk("ce_dis_count", count, 0);
        chk("ce_dis_drop", drop_cnt, 0);

        // async reset mid-drain
        for (int i = 0; i < 5; i++) push_pc(32'(800 + 4 * i), 0);
        idle(1, 1);
        idle(1, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", trace_valid, 1'b0);
        chk("arst_count", count, 0);
        exp_q.delete(); m_ovf = 0; m_drop = 0;
        @(negedge clk);
        reset = 1'b0;
        push_pc(32'h500, 0);
        chk("arst_next_valid", trace_valid, 1'b1);
        chk("arst_next_pc", trace_data[PC_LSB +: 32], 32'h500);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 59) == 0, $urandom, $urandom, $urandom_range(0, 1),
                5'($urandom), $urandom);
        end
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
